// File: rtl/ball_pkg.sv
// Shared types and geometry for the paddle-game pipeline (paddle, ball, VGA stages).
package ball_pkg;

    localparam int unsigned C_SCREEN_W   = 640;
    localparam int unsigned C_SCREEN_H   = 480;
    localparam int unsigned C_PAD_W      = 100;
    localparam int unsigned C_BALL_SZ    = 8;
    localparam int unsigned C_STEP       = 2;
    localparam int unsigned C_TICK_BITS  = 21;
    localparam int unsigned C_LIVES      = 3;
    localparam int unsigned C_MISS_TICKS = 60;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned CALC_W  = COORD_W + 1;
    localparam int unsigned LIVES_W = 2;

    // Ball sits centred on the paddle's reset position 270/379.
    localparam int unsigned RST_BALL_X = 316;
    localparam int unsigned RST_BALL_Y = 371;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        RUN   = 2'd1,
        MISS  = 2'd2,
        OVER  = 2'd3
    } ball_state_e;

endpackage

// File: rtl/ball_ctrl_if.sv
// Paddle-in / ball-out bundle between the paddle stage, ball engine and renderer.
interface ball_ctrl_if;
    import ball_pkg::*;

    logic [COORD_W-1:0] pad_x;
    logic [COORD_W-1:0] pad_y;
    logic               launch;
    logic               pause;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [LIVES_W-1:0] lives;
    logic               miss;
    logic               game_over;

    modport master (
        output pad_x, pad_y, launch, pause,
        input  ball_x, ball_y, lives, miss, game_over
    );

    modport slave (
        input  pad_x, pad_y, launch, pause,
        output ball_x, ball_y, lives, miss, game_over
    );

endinterface

// File: rtl/frame_tick.sv
// Free-running frame divider: one-cycle tick each time the counter wraps to 0.
module frame_tick #(
    parameter int unsigned TICK_BITS = 21
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    logic [TICK_BITS-1:0] r_cnt;
    logic                 r_tick;

    // Count every clk; flag the cycle in which the counter reads 0 after a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + TICK_BITS'(1);
            r_tick <= (r_cnt == {TICK_BITS{1'b1}});
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/ball_ctrl.sv
// Ball-motion engine: per-tick movement, wall/paddle bounces, misses and lives.
module ball_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned SCREEN_W   = ball_pkg::C_SCREEN_W,
    parameter int unsigned SCREEN_H   = ball_pkg::C_SCREEN_H,
    parameter int unsigned PAD_W      = ball_pkg::C_PAD_W,
    parameter int unsigned BALL_SZ    = ball_pkg::C_BALL_SZ,
    parameter int unsigned STEP       = ball_pkg::C_STEP,
    parameter int unsigned TICK_BITS  = ball_pkg::C_TICK_BITS,
    parameter int unsigned LIVES      = ball_pkg::C_LIVES,
    parameter int unsigned MISS_TICKS = ball_pkg::C_MISS_TICKS
) (
    input  logic        clk,
    input  logic        rst,
    ball_ctrl_if.slave  bus
);

    localparam int unsigned MCW = (MISS_TICKS > 1) ? $clog2(MISS_TICKS) : 1;

    localparam logic [CALC_W-1:0]  K_STEP   = CALC_W'(STEP);
    localparam logic [CALC_W-1:0]  K_BALL   = CALC_W'(BALL_SZ);
    localparam logic [CALC_W-1:0]  K_HALF   = CALC_W'(BALL_SZ / 2);
    localparam logic [CALC_W-1:0]  K_PADW   = CALC_W'(PAD_W);
    localparam logic [CALC_W-1:0]  K_THIRD1 = CALC_W'(PAD_W / 3);
    localparam logic [CALC_W-1:0]  K_THIRD2 = CALC_W'((2 * PAD_W) / 3);
    localparam logic [CALC_W-1:0]  K_XMAX   = CALC_W'(SCREEN_W - BALL_SZ);
    localparam logic [CALC_W-1:0]  K_YMAX   = CALC_W'(SCREEN_H - BALL_SZ);
    localparam logic [COORD_W-1:0] K_SRV_DX = COORD_W'(PAD_W / 2 - BALL_SZ / 2);
    localparam logic [COORD_W-1:0] K_SRV_DY = COORD_W'(BALL_SZ);

    ball_state_e        r_state, w_next_state;
    logic [COORD_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic               r_vxn, r_vyn, w_vxn_nxt, w_vyn_nxt;
    logic [LIVES_W-1:0] r_lives, w_lives_nxt;
    logic               r_miss, w_miss_nxt;
    logic               r_game_over, w_game_over_nxt;
    logic [MCW-1:0]     r_mcnt, w_mcnt_nxt;

    logic               w_tick, w_upd;
    logic [CALC_W-1:0]  w_bx, w_by, w_px, w_py, w_cx;
    logic               w_hit, w_floor, w_miss_evt;

    frame_tick #(.TICK_BITS(TICK_BITS)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    assign w_upd = w_tick & ~bus.pause;

    // Geometry in 13 bits so sums never wrap.
    assign w_bx = {1'b0, r_x};
    assign w_by = {1'b0, r_y};
    assign w_px = {1'b0, bus.pad_x};
    assign w_py = {1'b0, bus.pad_y};
    assign w_cx = w_bx + K_HALF;

    assign w_hit = ~r_vyn
                 && (w_by + K_BALL <= w_py)
                 && (w_by + K_BALL + K_STEP >= w_py)
                 && (w_bx + K_BALL > w_px)
                 && (w_bx < w_px + K_PADW);
    assign w_floor    = (w_by + K_STEP >= K_YMAX);
    assign w_miss_evt = ~r_vyn & ~w_hit & w_floor;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= SERVE;
        else     r_state <= w_next_state;
    end

    // Next-state decode, advanced only on unpaused ticks.
    always_comb begin
        w_next_state = r_state;
        if (w_upd) begin
            case (r_state)
                SERVE: if (bus.launch) w_next_state = RUN;
                RUN:   if (w_miss_evt) w_next_state = MISS;
                MISS:  if (r_mcnt == '0) w_next_state = (r_lives != '0) ? SERVE : OVER;
                default: w_next_state = r_state;
            endcase
        end
    end

    // Per-tick ball, direction, lives and timer updates.
    always_comb begin
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_vxn_nxt       = r_vxn;
        w_vyn_nxt       = r_vyn;
        w_lives_nxt     = r_lives;
        w_mcnt_nxt      = r_mcnt;
        w_miss_nxt      = 1'b0;
        w_game_over_nxt = (w_next_state == OVER);
        if (w_upd) begin
            case (r_state)
                SERVE: begin
                    w_x_nxt = bus.pad_x + K_SRV_DX;
                    w_y_nxt = bus.pad_y - K_SRV_DY;
                    if (bus.launch) begin
                        w_vxn_nxt = 1'b0;
                        w_vyn_nxt = 1'b1;
                    end
                end
                RUN: begin
                    if (r_vxn) begin
                        if (w_bx < K_STEP) begin
                            w_x_nxt   = '0;
                            w_vxn_nxt = 1'b0;
                        end else begin
                            w_x_nxt = COORD_W'(w_bx - K_STEP);
                        end
                    end else if (w_bx + K_STEP > K_XMAX) begin
                        w_x_nxt   = COORD_W'(K_XMAX);
                        w_vxn_nxt = 1'b1;
                    end else begin
                        w_x_nxt = COORD_W'(w_bx + K_STEP);
                    end

                    if (r_vyn) begin
                        if (w_by < K_STEP) begin
                            w_y_nxt   = '0;
                            w_vyn_nxt = 1'b0;
                        end else begin
                            w_y_nxt = COORD_W'(w_by - K_STEP);
                        end
                    end else if (w_hit) begin
                        // Paddle third struck decides the outgoing X direction.
                        w_y_nxt   = COORD_W'(w_py - K_BALL);
                        w_vyn_nxt = 1'b1;
                        if (w_cx < w_px + K_THIRD1)       w_vxn_nxt = 1'b1;
                        else if (w_cx >= w_px + K_THIRD2) w_vxn_nxt = 1'b0;
                        else                              w_vxn_nxt = r_vxn;
                    end else if (w_floor) begin
                        w_y_nxt     = COORD_W'(K_YMAX);
                        w_lives_nxt = (r_lives != '0) ? r_lives - LIVES_W'(1) : '0;
                        w_mcnt_nxt  = MCW'(MISS_TICKS - 1);
                        w_miss_nxt  = 1'b1;
                    end else begin
                        w_y_nxt = COORD_W'(w_by + K_STEP);
                    end
                end
                MISS: if (r_mcnt != '0) w_mcnt_nxt = r_mcnt - MCW'(1);
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x         <= COORD_W'(RST_BALL_X);
            r_y         <= COORD_W'(RST_BALL_Y);
            r_vxn       <= 1'b0;
            r_vyn       <= 1'b1;
            r_lives     <= LIVES_W'(LIVES);
            r_mcnt      <= '0;
            r_miss      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_vxn       <= w_vxn_nxt;
            r_vyn       <= w_vyn_nxt;
            r_lives     <= w_lives_nxt;
            r_mcnt      <= w_mcnt_nxt;
            r_miss      <= w_miss_nxt;
            r_game_over <= w_game_over_nxt;
        end
    end

    assign bus.ball_x    = r_x;
    assign bus.ball_y    = r_y;
    assign bus.lives     = r_lives;
    assign bus.miss      = r_miss;
    assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_ball_ctrl.sv
// Scoreboard bench for ball_ctrl with a 4-clk frame tick.
module tb_ball_ctrl;

    logic clk = 1'b0;
    logic rst;

    ball_ctrl_if bus();

    ball_ctrl #(.TICK_BITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int lives;
        int miss;
        int go;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (0 serve, 1 run, 2 miss, 3 over).
    int m_x, m_y, m_lives, m_mcnt, m_st, m_hits;
    bit m_vxn, m_vyn;
    bit last_miss;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_x = 316; m_y = 371; m_vxn = 1'b0; m_vyn = 1'b1;
        m_lives = 3; m_st = 0; m_mcnt = 0; last_miss = 1'b0;
    endfunction

    function automatic void model_step(input int px, input int py, input bit launch, input bit pause);
        int   nx, ny, c;
        bit   nvx, nvy, hit, mflag;
        exp_t e;
        mflag = 1'b0;
        if (!pause) begin
            case (m_st)
                0: begin
                    m_x = px + 46;
                    m_y = py - 8;
                    if (launch) begin m_st = 1; m_vxn = 1'b0; m_vyn = 1'b1; end
                end
                1: begin
                    nx = m_x; ny = m_y; nvx = m_vxn; nvy = m_vyn;
                    if (m_vxn) begin
                        if (m_x - 2 < 0) begin nx = 0; nvx = 1'b0; end
                        else nx = m_x - 2;
                    end else begin
                        if (m_x + 2 > 632) begin nx = 632; nvx = 1'b1; end
                        else nx = m_x + 2;
                    end
                    hit = !m_vyn && (m_y + 8 <= py) && (m_y + 10 >= py)
                          && (m_x + 8 > px) && (m_x < px + 100);
                    if (m_vyn) begin
                        if (m_y - 2 < 0) begin ny = 0; nvy = 1'b0; end
                        else ny = m_y - 2;
                    end else if (hit) begin
                        ny = py - 8; nvy = 1'b1; m_hits++;
                        c = m_x + 4;
                        if (c < px + 33)       nvx = 1'b1;
                        else if (c >= px + 66) nvx = 1'b0;
                        else                   nvx = m_vxn;
                    end else if (m_y + 2 >= 472) begin
                        ny = 472; mflag = 1'b1; m_st = 2; m_mcnt = 59;
                        if (m_lives > 0) m_lives--;
                    end else begin
                        ny = m_y + 2;
                    end
                    m_x = nx; m_y = ny; m_vxn = nvx; m_vyn = nvy;
                end
                2: begin
                    if (m_mcnt == 0) m_st = (m_lives != 0) ? 0 : 3;
                    else m_mcnt--;
                end
                default: ;
            endcase
        end
        last_miss = mflag;
        e.x = m_x; e.y = m_y; e.lives = m_lives; e.miss = int'(mflag); e.go = (m_st == 3) ? 1 : 0;
        sb_q.push_back(e);
    endfunction

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Wait for the next tick cycle, predict its result, return just after the update edge.
    task automatic do_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (!dut.w_tick) begin
            n++;
            if (n > 16) begin
                checks++; errors++;
                $display("FAIL tick_timeout no tick within 16 clks at %0t", $time);
                finish_run();
            end
            @(negedge clk);
        end
        model_step(int'(bus.pad_x), int'(bus.pad_y), bus.launch, bus.pause);
        @(posedge clk);
        #1;
    endtask

    // Monitor: after every tick cycle pop and compare; otherwise miss must stay low.
    bit tick_d = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (tick_d) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty got update expected none at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_ball_x", int'(bus.ball_x), e.x);
                chk("sb_ball_y", int'(bus.ball_y), e.y);
                chk("sb_lives", int'(bus.lives), e.lives);
                chk("sb_miss", int'(bus.miss), e.miss);
                chk("sb_game_over", int'(bus.game_over), e.go);
            end
        end else begin
            chk("miss_idle", int'(bus.miss), 0);
        end
        tick_d = dut.w_tick & ~rst;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, int'(bus.ball_x), 316);
        chk({tag, "_y"}, int'(bus.ball_y), 371);
        chk({tag, "_lives"}, int'(bus.lives), 3);
        chk({tag, "_miss"}, int'(bus.miss), 0);
        chk({tag, "_go"}, int'(bus.game_over), 0);
    endtask

    initial begin
        int n;
        int tgt;
        int px;
        int ox;
        int oy;
        rst = 1'b1;
        bus.pad_x = 12'd270; bus.pad_y = 12'd379;
        bus.launch = 1'b0; bus.pause = 1'b0;
        m_hits = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Serve: ball rides the paddle.
        do_tick();
        chk("serve_x", int'(bus.ball_x), 316);
        bus.pad_x = 12'd300;
        do_tick();
        chk("serve_follow_x", int'(bus.ball_x), 346);
        chk("serve_follow_y", int'(bus.ball_y), 371);

        // Launch, then first RUN tick moves up-right.
        bus.pad_x = 12'd270; bus.launch = 1'b1;
        do_tick();
        bus.launch = 1'b0;
        do_tick();
        chk("run1_x", int'(bus.ball_x), 318);
        chk("run1_y", int'(bus.ball_y), 369);

        // Pause freezes the ball.
        bus.pause = 1'b1;
        repeat (10) do_tick();
        chk("pause_x", int'(bus.ball_x), 318);
        chk("pause_y", int'(bus.ball_y), 369);
        bus.pause = 1'b0;
        do_tick();
        chk("unpause_x", int'(bus.ball_x), 320);
        chk("unpause_y", int'(bus.ball_y), 367);

        // Mid-run reset restores everything immediately.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        sb_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Serve from pad_x 215 so the ball reaches the top-right corner on one tick.
        bus.pad_x = 12'd215; bus.launch = 1'b1;
        do_tick();
        bus.launch = 1'b0;
        chk("srv215_x", int'(bus.ball_x), 261);
        repeat (185) do_tick();
        chk("pre_corner_x", int'(bus.ball_x), 631);
        chk("pre_corner_y", int'(bus.ball_y), 1);
        do_tick();
        chk("corner_x", int'(bus.ball_x), 632);
        chk("corner_y", int'(bus.ball_y), 0);
        do_tick();
        chk("post_corner_x", int'(bus.ball_x), 630);
        chk("post_corner_y", int'(bus.ball_y), 2);

        // Descend onto a paddle whose left third is under the ball.
        repeat (184) begin
            bus.pad_x = 12'(m_x - 10);
            do_tick();
        end
        bus.pad_x = 12'(m_x - 10);
        do_tick();
        chk("hit_left_x", int'(bus.ball_x), 260);
        chk("hit_left_y", int'(bus.ball_y), 371);
        do_tick();
        chk("after_hit_x", int'(bus.ball_x), 258);
        chk("after_hit_y", int'(bus.ball_y), 369);

        // Two more paddle hits: middle third, then right third.
        n = 0;
        while (m_hits < 3 && m_st == 1 && n < 3000) begin
            tgt = (m_hits == 1) ? 49 : 84;
            if (!m_vyn) begin
                px = m_x + 4 - tgt;
                bus.pad_x = 12'((px < 0) ? 0 : px);
            end
            do_tick();
            n++;
        end

        // Three misses with the paddle out of the way.
        bus.launch = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.pad_x = 12'd1000;
            n = 0;
            last_miss = 1'b0;
            while (!last_miss && n < 2000) begin
                do_tick();
                n++;
            end
            if (n >= 2000) begin
                checks++; errors++;
                $display("FAIL miss_wait got no miss expected one within 2000 ticks");
            end
            chk("miss_pulse", int'(bus.miss), 1);
            chk("miss_lives", int'(bus.lives), 2 - k);
            chk("miss_y", int'(bus.ball_y), 472);
            @(posedge clk);
            #1;
            chk("miss_width", int'(bus.miss), 0);
            bus.pad_x = 12'd270;
            repeat (59) do_tick();
            chk("miss_hold_y", int'(bus.ball_y), 472);
            chk("miss_hold_go", int'(bus.game_over), 0);
            do_tick();
            chk("miss_end_go", int'(bus.game_over), (k == 2) ? 1 : 0);
            if (k < 2) begin
                do_tick();
                chk("reserve_x", int'(bus.ball_x), 316);
                chk("reserve_y", int'(bus.ball_y), 371);
            end
        end

        // OVER: ball frozen, launch ignored.
        ox = int'(bus.ball_x);
        oy = int'(bus.ball_y);
        repeat (5) do_tick();
        chk("over_go", int'(bus.game_over), 1);
        chk("over_lives", int'(bus.lives), 0);
        chk("over_x", int'(bus.ball_x), ox);
        chk("over_y", int'(bus.ball_y), oy);

        @(negedge clk);
        @(negedge clk);
        finish_run();
    end

endmodule
